pattern_load_sequencer: RTL and testbench
=========================================

PATTERN_LOAD_SEQUENCER -- requirements
Module: pattern_load_sequencer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- N, 4, bytes per word (2..8)
- MATCH_TARGET, 5, consecutive word matches required to declare lock (1..255)

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge
- rst, in, 1, synchronous reset, active-high
- start, in, 1, begin a pattern-load/detect run
- abort, in, 1, cancel the run and return to IDLE
- byte_in, in, 8, serial byte stream
- byte_valid, in, 1, byte_in is valid this cycle
- byte_ready, out, 1, block accepts a byte this cycle
- pattern, out, 8*N, loaded reference word; byte 0 in [7:0], byte k in [8k+7:8k]
- pattern_valid, out, 1, pattern register holds a complete word
- word_match, out, 1, one-cycle pulse when an assembled detect word equals pattern
- word_mismatch, out, 1, one-cycle pulse when an assembled detect word differs
- found, out, 1, lock declared; held until restart or abort
- busy, out, 1, high in LOAD and DETECT

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, DETECT and DONE.
REQ-004 Transitions:
- IDLE -> LOAD on start.
- LOAD -> DETECT on acceptance of the Nth load byte.
- DETECT -> DONE when the match count reaches MATCH_TARGET.
- DONE -> LOAD on start.
- Any state -> IDLE on abort.
REQ-005 A byte SHALL be accepted only when byte_valid and byte_ready are both high; byte_ready SHALL be high exactly in LOAD and DETECT (registered from state, so no combinational path from byte_valid).
REQ-006 A byte counter (width clog2(N)) SHALL index the accepted byte into lane k, counting 0..N-1, and SHALL wrap to 0 after lane N-1; it SHALL be cleared on entry to LOAD and DETECT.
REQ-007 In LOAD, accepted bytes SHALL be written into pattern lane k. pattern_valid SHALL rise the cycle after the Nth accept and stay high until abort, rst or the next start.
REQ-008 In DETECT, accepted bytes SHALL fill an internal word register.
- On the Nth accept, the completed word (including the current byte) SHALL be compared with pattern.
- word_match or word_mismatch SHALL pulse for exactly one cycle, one cycle after that accept (latency 1).
REQ-009 The match counter SHALL be 8 bits wide.
- Increment on each match; clear to 0 on each mismatch; no wrap.
- Reaching MATCH_TARGET SHALL move the FSM to DONE and set found in the same cycle the word_match pulse is asserted.
REQ-010 In DONE, byte_ready SHALL be 0 and found SHALL stay 1.
REQ-011 start received in LOAD or DETECT SHALL be ignored.
REQ-012 start received in IDLE or DONE SHALL:
- clear found, pattern_valid, both counters and the pattern register;
- enter LOAD.
REQ-013 abort SHALL take priority over start and over byte acceptance in the same cycle. In the cycle after abort:
- state is IDLE;
- found, pattern_valid, word_match, word_mismatch, busy and byte_ready are all 0;
- the pattern register and counters are cleared.
REQ-014 When byte_valid is low, no counter or register SHALL change; gaps of any length between bytes SHALL be tolerated.

Reset
REQ-015 When rst is high at a clock edge:
- state SHALL become IDLE;
- every output SHALL be 0 (pattern all-zero);
- all counters and the internal word register SHALL be cleared.
REQ-016 rst SHALL override abort, start and byte acceptance.

Structure
REQ-017 The state encoding enum and the default N and MATCH_TARGET constants SHALL reside in the shared package prbs_pkg.
REQ-018 Lane assembly SHALL be one sub-module, byte_word_assembler (parameter N; inputs: clear, enable, byte; outputs: word, last_lane), instantiated twice: once for pattern, once for the detect word.

Verification
REQ-019 Load and lock: N=4, MATCH_TARGET=2; start; bytes 0x11,0x22,0x33,0x44.
- pattern=0x44332211 and pattern_valid=1 one cycle after the 4th byte.
- Two repeats of the same 4 bytes give two word_match pulses.
- found=1 on the second pulse; byte_ready=0 afterwards.
REQ-020 Mismatch reset: after one match, send 0x11,0x22,0x33,0x45.
- word_mismatch pulses once and the match count returns to 0.
- Two further correct words are then needed before found=1.
REQ-021 Gapped input: byte_valid low for 3 cycles between every byte.
- pattern and match results are identical to the gap-free case.
REQ-022 Abort mid-LOAD after 2 bytes, with start high in the same cycle.
- Next cycle: IDLE, busy=0, pattern=0.
- A new start reloads from lane 0.
REQ-023 Restart from DONE: start while found=1.
- found and pattern_valid clear; state is LOAD.
- New pattern 0xA5A5A5A5 loads correctly.
REQ-024 Synchronous reset asserted in DETECT with byte_valid high.
- At the next edge all outputs are 0 and the byte is not accepted.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the pattern load/detect sequencer.
// Contents:
//   - default bytes-per-word and lock-threshold constants
//   - sequencer state encoding
//   - helper that decodes which states consume input bytes
package prbs_pkg;

  localparam int DEFAULT_N            = 4;
  localparam int DEFAULT_MATCH_TARGET = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DETECT = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Byte stream is only consumed while loading the pattern or detecting words.
  function automatic logic accepts_bytes(input seq_state_t s);
    return (s == ST_LOAD) || (s == ST_DETECT);
  endfunction

endpackage

// File: rtl/pattern_load_sequencer_if.sv
// Handshake and result bundle of the pattern load/detect sequencer.
// master: stream/control source (drives start, abort, byte_in, byte_valid).
// slave : the sequencer (drives byte_ready, pattern, pattern_valid,
//         word_match, word_mismatch, found, busy).
interface pattern_load_sequencer_if
  import prbs_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic           start;
  logic           abort;
  logic [7:0]     byte_in;
  logic           byte_valid;
  logic           byte_ready;
  logic [8*N-1:0] pattern;
  logic           pattern_valid;
  logic           word_match;
  logic           word_mismatch;
  logic           found;
  logic           busy;

  modport master (
    output start, abort, byte_in, byte_valid,
    input  byte_ready, pattern, pattern_valid, word_match, word_mismatch,
           found, busy
  );

  modport slave (
    input  start, abort, byte_in, byte_valid,
    output byte_ready, pattern, pattern_valid, word_match, word_mismatch,
           found, busy
  );

endinterface

// File: rtl/byte_word_assembler.sv
// Assembles a serial byte stream into an N-byte word, lane 0 first.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - zero the word and restart at lane 0 (wins over enable)
//   enable     - write byte_in into the current lane and advance
//   byte_in    - incoming byte
//   word       - registered word; lane k in [8k+7:8k]
//   last_lane  - the next enabled byte lands in lane N-1
module byte_word_assembler
  import prbs_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           enable,
  input  logic [7:0]     byte_in,
  output logic [8*N-1:0] word,
  output logic           last_lane
);

  localparam int CW = $clog2(N);

  logic [CW-1:0]  lane_r;
  logic [8*N-1:0] word_r;

  // Lane pointer and word storage; pointer wraps to lane 0 after lane N-1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_r <= {CW{1'b0}};
      word_r <= {(8*N){1'b0}};
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (lane_r == CW'(k)) begin
          word_r[8*k +: 8] <= byte_in;
        end
      end
      lane_r <= (lane_r == CW'(N-1)) ? {CW{1'b0}} : lane_r + CW'(1);
    end
  end

  assign word      = word_r;
  assign last_lane = (lane_r == CW'(N-1));

endmodule

// File: rtl/pattern_load_sequencer.sv
// Loads an N-byte reference pattern from a byte stream, then compares
// subsequent N-byte words against it and declares lock after MATCH_TARGET
// consecutive matches.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of pattern_load_sequencer_if (start/abort control,
//          byte stream handshake, pattern, match pulses, found, busy)
module pattern_load_sequencer
  import prbs_pkg::*;
#(
  parameter int N            = DEFAULT_N,
  parameter int MATCH_TARGET = DEFAULT_MATCH_TARGET
) (
  input  logic                     clk,
  input  logic                     rst,
  pattern_load_sequencer_if.slave  bus
);

  seq_state_t     state_r, next_state_s;
  logic [7:0]     match_cnt_r, match_cnt_next_s, cnt_inc_s;
  logic           found_r, found_next_s;
  logic           pattern_valid_r, pattern_valid_next_s;
  logic           word_match_r, word_mismatch_r;
  logic           match_pulse_s, mismatch_pulse_s;
  logic           byte_ready_r, busy_r;
  logic           accept_s, load_acc_s, det_acc_s;
  logic           pat_clear_s, det_clear_s;
  logic           pat_last_s, det_last_s, word_eq_s;
  logic [8*N-1:0] pat_word_s, det_word_s, cand_word_s;

  // abort blocks acceptance so no lane is written in the abort cycle
  assign accept_s   = bus.byte_valid & byte_ready_r & ~bus.abort;
  assign load_acc_s = accept_s & (state_r == ST_LOAD);
  assign det_acc_s  = accept_s & (state_r == ST_DETECT);

  // Match counter saturates instead of wrapping
  assign cnt_inc_s  = (match_cnt_r == 8'hFF) ? 8'hFF : match_cnt_r + 8'd1;

  byte_word_assembler #(.N(N)) u_pattern_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (pat_clear_s),
    .enable    (load_acc_s),
    .byte_in   (bus.byte_in),
    .word      (pat_word_s),
    .last_lane (pat_last_s)
  );

  byte_word_assembler #(.N(N)) u_detect_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (det_clear_s),
    .enable    (det_acc_s),
    .byte_in   (bus.byte_in),
    .word      (det_word_s),
    .last_lane (det_last_s)
  );

  // Completed detect word: stored lanes plus the byte arriving in the last lane.
  always_comb begin
    cand_word_s                = det_word_s;
    cand_word_s[8*N-1 -: 8]    = bus.byte_in;
  end

  assign word_eq_s = (cand_word_s == pat_word_s);

  // Next-state, counter and flag updates; abort overrides everything else.
  always_comb begin
    next_state_s         = state_r;
    match_cnt_next_s     = match_cnt_r;
    found_next_s         = found_r;
    pattern_valid_next_s = pattern_valid_r;
    match_pulse_s        = 1'b0;
    mismatch_pulse_s     = 1'b0;
    pat_clear_s          = 1'b0;
    det_clear_s          = 1'b0;

    if (bus.abort) begin
      next_state_s         = ST_IDLE;
      match_cnt_next_s     = 8'd0;
      found_next_s         = 1'b0;
      pattern_valid_next_s = 1'b0;
      pat_clear_s          = 1'b1;
      det_clear_s          = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            next_state_s         = ST_LOAD;
            match_cnt_next_s     = 8'd0;
            found_next_s         = 1'b0;
            pattern_valid_next_s = 1'b0;
            pat_clear_s          = 1'b1;
            det_clear_s          = 1'b1;
          end else begin
            next_state_s = state_r;
          end
        end
        ST_LOAD: begin
          if (load_acc_s && pat_last_s) begin
            next_state_s         = ST_DETECT;
            pattern_valid_next_s = 1'b1;
            det_clear_s          = 1'b1;
          end else begin
            next_state_s = ST_LOAD;
          end
        end
        ST_DETECT: begin
          if (det_acc_s && det_last_s) begin
            if (word_eq_s) begin
              match_pulse_s    = 1'b1;
              match_cnt_next_s = cnt_inc_s;
              if (cnt_inc_s >= 8'(MATCH_TARGET)) begin
                next_state_s = ST_DONE;
                found_next_s = 1'b1;
              end else begin
                next_state_s = ST_DETECT;
              end
            end else begin
              mismatch_pulse_s = 1'b1;
              match_cnt_next_s = 8'd0;
            end
          end else begin
            next_state_s = ST_DETECT;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and registered outputs; byte_ready/busy follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      match_cnt_r     <= 8'd0;
      found_r         <= 1'b0;
      pattern_valid_r <= 1'b0;
      word_match_r    <= 1'b0;
      word_mismatch_r <= 1'b0;
      byte_ready_r    <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      match_cnt_r     <= match_cnt_next_s;
      found_r         <= found_next_s;
      pattern_valid_r <= pattern_valid_next_s;
      word_match_r    <= match_pulse_s;
      word_mismatch_r <= mismatch_pulse_s;
      byte_ready_r    <= accepts_bytes(next_state_s);
      busy_r          <= accepts_bytes(next_state_s);
    end
  end

  assign bus.byte_ready    = byte_ready_r;
  assign bus.pattern       = pat_word_s;
  assign bus.pattern_valid = pattern_valid_r;
  assign bus.word_match    = word_match_r;
  assign bus.word_mismatch = word_mismatch_r;
  assign bus.found         = found_r;
  assign bus.busy          = busy_r;

endmodule

// File: tb/tb_pattern_load_sequencer.sv
// Scoreboard bench for pattern_load_sequencer (N=4, MATCH_TARGET=2).
// Stimulus tasks push the expected pattern-load and word-compare events;
// a negedge monitor pops and compares whenever the DUT raises pattern_valid
// or pulses word_match/word_mismatch.
module tb_pattern_load_sequencer;

  localparam int N  = 4;
  localparam int MT = 2;

  localparam int EV_LOAD     = 0;
  localparam int EV_MATCH    = 1;
  localparam int EV_MISMATCH = 2;

  typedef struct {
    int             kind;
    logic [8*N-1:0] pat;
    logic           found;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  int   mon_kind;
  logic pv_prev = 1'b0;

  pattern_load_sequencer_if #(.N(N)) bus();

  pattern_load_sequencer #(.N(N), .MATCH_TARGET(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each DUT event against the oldest expected one.
  always @(negedge clk) begin
    if (bus.pattern_valid && !pv_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load actual_pattern=%0h expected=no_event", bus.pattern);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != EV_LOAD || bus.pattern !== mon_e.pat) begin
          errors++;
          $display("FAIL load_event actual=load:%0h expected=kind%0d:%0h",
                   bus.pattern, mon_e.kind, mon_e.pat);
        end
      end
    end
    if (bus.word_match || bus.word_mismatch) begin
      mon_kind = bus.word_match ? EV_MATCH : EV_MISMATCH;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_compare actual=kind%0d expected=no_event", mon_kind);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_kind || (bus.word_match && bus.word_mismatch) ||
            bus.found !== mon_e.found) begin
          errors++;
          $display("FAIL compare_event actual=match%0b/mismatch%0b/found%0b expected=kind%0d/found%0b",
                   bus.word_match, bus.word_mismatch, bus.found, mon_e.kind, mon_e.found);
        end
      end
    end
    pv_prev = bus.pattern_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_bytes(input logic [8*N-1:0] w, input int gap);
    for (int i = 0; i < N; i++) begin
      send_byte(w[8*i +: 8], gap);
    end
  endtask

  task automatic load_word(input logic [8*N-1:0] w, input int gap);
    exp_q.push_back('{EV_LOAD, w, 1'b0});
    send_bytes(w, gap);
  endtask

  task automatic detect_word(input logic [8*N-1:0] w, input int gap,
                             input int kind, input logic found_exp);
    exp_q.push_back('{kind, {(8*N){1'b0}}, found_exp});
    send_bytes(w, gap);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic outputs_zero(input string p);
    check({p, "_pattern"},       64'(bus.pattern),       64'd0);
    check({p, "_pattern_valid"}, 64'(bus.pattern_valid), 64'd0);
    check({p, "_found"},         64'(bus.found),         64'd0);
    check({p, "_busy"},          64'(bus.busy),          64'd0);
    check({p, "_byte_ready"},    64'(bus.byte_ready),    64'd0);
    check({p, "_word_match"},    64'(bus.word_match),    64'd0);
    check({p, "_word_mismatch"}, 64'(bus.word_mismatch), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    rst            = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("reset");
    tick();

    // Load 0x44332211 and lock after two matching words.
    pulse_start();
    @(negedge clk);
    check("start_busy",       64'(bus.busy),       64'd1);
    check("start_byte_ready", 64'(bus.byte_ready), 64'd1);
    tick();
    load_word(32'h44332211, 0);
    detect_word(32'h44332211, 0, EV_MATCH, 1'b0);
    detect_word(32'h44332211, 0, EV_MATCH, 1'b1);
    drain("lock_drain");
    @(negedge clk);
    check("lock_found",      64'(bus.found),      64'd1);
    check("lock_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("lock_busy",       64'(bus.busy),       64'd0);
    tick();

    // Restart from DONE with a new pattern.
    pulse_start();
    @(negedge clk);
    check("restart_found", 64'(bus.found),         64'd0);
    check("restart_pv",    64'(bus.pattern_valid), 64'd0);
    check("restart_busy",  64'(bus.busy),          64'd1);
    tick();
    load_word(32'hA5A5A5A5, 0);
    detect_word(32'hA5A5A5A5, 0, EV_MATCH, 1'b0);
    detect_word(32'hA5A5A5A5, 0, EV_MATCH, 1'b1);
    drain("restart_drain");

    // A mismatch after one match resets the count: two more matches needed.
    pulse_start();
    load_word(32'h44332211, 0);
    detect_word(32'h44332211, 0, EV_MATCH,    1'b0);
    detect_word(32'h45332211, 0, EV_MISMATCH, 1'b0);
    detect_word(32'h44332211, 0, EV_MATCH,    1'b0);
    detect_word(32'h44332211, 0, EV_MATCH,    1'b1);
    drain("mismatch_drain");

    // Same sequence with three idle cycles between bytes.
    pulse_start();
    load_word(32'h44332211, 3);
    detect_word(32'h44332211, 3, EV_MATCH,    1'b0);
    detect_word(32'h45332211, 3, EV_MISMATCH, 1'b0);
    detect_word(32'h44332211, 3, EV_MATCH,    1'b0);
    detect_word(32'h44332211, 3, EV_MATCH,    1'b1);
    drain("gapped_drain");

    // Abort mid-load with start and a valid byte in the same cycle.
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bus.abort      = 1'b1;
    bus.start      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h33;
    tick();
    bus.abort      = 1'b0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    outputs_zero("abort");
    tick();
    pulse_start();
    load_word(32'h44332211, 0);
    detect_word(32'h44332211, 0, EV_MATCH, 1'b0);
    drain("abort_reload_drain");

    // Synchronous reset in DETECT while a byte is offered.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst            = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h33;
    tick();
    rst            = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    outputs_zero("rst_detect");
    tick();
    pulse_start();
    load_word(32'h5A6B7C8D, 0);
    detect_word(32'h5A6B7C8D, 0, EV_MATCH, 1'b0);
    detect_word(32'h5A6B7C8D, 0, EV_MATCH, 1'b1);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
